// File: rtl/gate16_checker_pkg.sv
// Shared types and constants for the gate16 response checker:
// state encoding, mismatch-mask bit positions and counter width.
package gate16_checker_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MASK_ANOT  = 0;
  localparam int MASK_BNOT  = 1;
  localparam int MASK_AANDB = 2;
  localparam int MASK_AORB  = 3;
  localparam int MASK_W     = 4;

  typedef struct packed {
    logic [CNT_W-1:0] anot;
    logic [CNT_W-1:0] bnot;
    logic [CNT_W-1:0] aandb;
    logic [CNT_W-1:0] aorb;
  } buses_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gate16_golden.sv
// Behavioural reference for the 16-bit gate library: the four expected
// buses, deliberately independent of the gate cells being checked.
module gate16_golden
  import gate16_checker_pkg::*;
(
  input  logic [CNT_W-1:0] a,
  input  logic [CNT_W-1:0] b,
  output logic [CNT_W-1:0] exp_anot,
  output logic [CNT_W-1:0] exp_bnot,
  output logic [CNT_W-1:0] exp_aandb,
  output logic [CNT_W-1:0] exp_aorb
);

  assign exp_anot  = ~a;
  assign exp_bnot  = ~b;
  assign exp_aandb = a & b;
  assign exp_aorb  = a | b;

endmodule

// File: rtl/gate16_checker.sv
// Stimulus/response engine: drives a counting pattern into a 16-bit gate
// DUT, compares its results one cycle later and keeps error statistics.
module gate16_checker
  import gate16_checker_pkg::*;
#(
  parameter int NUM_VECTORS = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [CNT_W-1:0]  a,
  output logic [CNT_W-1:0]  b,
  input  logic [CNT_W-1:0]  anot,
  input  logic [CNT_W-1:0]  bnot,
  input  logic [CNT_W-1:0]  aandb,
  input  logic [CNT_W-1:0]  aorb,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [MASK_W-1:0] first_err_mask
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  a_reg, b_reg;
  logic [CNT_W-1:0]  a_inc;
  logic              last_vec;
  logic              start_run;

  buses_t            gold_now;
  buses_t            dut_s1_reg, gold_s1_reg;
  logic [CNT_W-1:0]  idx_s1_reg;
  logic              valid_s1_reg;

  logic [MASK_W-1:0] mismatch;
  logic              fail;

  logic [CNT_W-1:0]  err_count_reg;
  logic [CNT_W-1:0]  first_idx_reg;
  logic [MASK_W-1:0] first_mask_reg;
  logic              first_seen_reg;

  gate16_golden u_golden (
    .a         (a_reg),
    .b         (b_reg),
    .exp_anot  (gold_now.anot),
    .exp_bnot  (gold_now.bnot),
    .exp_aandb (gold_now.aandb),
    .exp_aorb  (gold_now.aorb)
  );

  // a_reg doubles as the vector index, since a = k for every vector.
  assign a_inc     = a_reg + 1'b1;
  assign last_vec  = (a_reg == LAST_IDX);
  assign start_run = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_vec) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (start_run) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if ((state_reg == RUN) && !last_vec) begin
      a_reg <= a_inc;
      b_reg <= a_inc >> 1;
    end
  end

  // Stage 1: capture DUT results and golden values for the vector on a/b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_reg <= 1'b0;
      dut_s1_reg   <= '0;
      gold_s1_reg  <= '0;
      idx_s1_reg   <= '0;
    end else begin
      valid_s1_reg <= (state_reg == RUN);
      if (state_reg == RUN) begin
        dut_s1_reg.anot  <= anot;
        dut_s1_reg.bnot  <= bnot;
        dut_s1_reg.aandb <= aandb;
        dut_s1_reg.aorb  <= aorb;
        gold_s1_reg      <= gold_now;
        idx_s1_reg       <= a_reg;
      end
    end
  end

  always_comb begin
    mismatch             = '0;
    mismatch[MASK_ANOT]  = (dut_s1_reg.anot  != gold_s1_reg.anot);
    mismatch[MASK_BNOT]  = (dut_s1_reg.bnot  != gold_s1_reg.bnot);
    mismatch[MASK_AANDB] = (dut_s1_reg.aandb != gold_s1_reg.aandb);
    mismatch[MASK_AORB]  = (dut_s1_reg.aorb  != gold_s1_reg.aorb);
  end

  assign fail = valid_s1_reg && (|mismatch);

  // start_run and fail never coincide: stage-1 valid is low in IDLE/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg  <= '0;
      first_idx_reg  <= '0;
      first_mask_reg <= '0;
      first_seen_reg <= 1'b0;
    end else if (start_run) begin
      err_count_reg  <= '0;
      first_idx_reg  <= '0;
      first_mask_reg <= '0;
      first_seen_reg <= 1'b0;
    end else if (fail) begin
      err_count_reg <= sat_inc(err_count_reg);
      if (!first_seen_reg) begin
        first_idx_reg  <= idx_s1_reg;
        first_mask_reg <= mismatch;
        first_seen_reg <= 1'b1;
      end
    end
  end

  assign a              = a_reg;
  assign b              = b_reg;
  assign busy           = (state_reg == RUN) || (state_reg == DRAIN);
  assign done           = (state_reg == DONE);
  assign pass           = done && (err_count_reg == '0);
  assign err_count      = err_count_reg;
  assign first_err_idx  = first_idx_reg;
  assign first_err_mask = first_mask_reg;

endmodule
